scale_divider: RTL and testbench

SCALE_DIVIDER -- requirements
Module: scale_divider

---
 rtl/scale_div_pkg.sv | 9 +
 rtl/scale_div_core.sv | 70 +++++++
 rtl/scale_divider.sv | 99 +++++++++
 tb/tb_scale_divider.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/scale_div_pkg.sv
// Shared state encoding and default constants for the reciprocal-scale divider.
package scale_div_pkg;
    localparam int DATA_W    = 32;
    localparam int FRAC_BITS = 24;
    localparam int QMAX      = 127;
    localparam int NUM_CH    = 4;

    typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;
endpackage

// File: rtl/scale_div_core.sv
// Iterative restoring divider: loads on start, asserts done once the quotient is final.
// SCALE_DIV_RADIX4_EN retires two quotient bits per cycle instead of one.
module scale_div_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] divisor,
    input  logic [DATA_W-1:0] dividend,
    output logic              done,
    output logic [DATA_W-1:0] quotient
);
    import scale_div_pkg::*;

`ifdef SCALE_DIV_RADIX4_EN
    localparam int STEPS = DATA_W / 2;
`else
    localparam int STEPS = DATA_W;
`endif
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    logic [DATA_W-1:0]   rem;
    logic [CNT_W-1:0]    cnt;
    logic                busy;
    logic [2*DATA_W-1:0] nxt;

    // One restoring step on {rem, quot}; the compare is DATA_W+1 wide so the
    // bit shifted out of rem still takes part.
    function automatic logic [2*DATA_W-1:0] step(input logic [2*DATA_W-1:0] rq,
                                                 input logic [DATA_W-1:0]   d);
        logic [DATA_W:0] r;
        logic            ge;
        r  = rq[2*DATA_W-1:DATA_W-1];
        ge = (r >= {1'b0, d});
        if (ge) r = r - {1'b0, d};
        return {r[DATA_W-1:0], rq[DATA_W-2:0], ge};
    endfunction

    always_comb begin
        nxt = step({rem, quotient}, divisor);
`ifdef SCALE_DIV_RADIX4_EN
        nxt = step(nxt, divisor);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem      <= '0;
            quotient <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (start) begin
            rem      <= '0;
            quotient <= dividend;
            cnt      <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else if (busy) begin
            {rem, quotient} <= nxt;
            cnt             <= cnt + 1'b1;
            if (cnt == LAST) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/scale_divider.sv
// Computes floor((QMAX << FRAC_BITS) / max_abs) per channel and caches it in a scale table.
// Optional macro SCALE_DIV_RADIX4_EN halves the divide latency (see scale_div_core).
module scale_divider #(
    parameter  int DATA_W    = scale_div_pkg::DATA_W,
    parameter  int FRAC_BITS = scale_div_pkg::FRAC_BITS,
    parameter  int QMAX      = scale_div_pkg::QMAX,
    parameter  int NUM_CH    = scale_div_pkg::NUM_CH,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_max_abs,
    input  logic [CH_W-1:0]   in_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_scale,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_zero,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [DATA_W-1:0] rd_scale
);
    import scale_div_pkg::*;

    localparam logic [DATA_W-1:0] DIVIDEND = DATA_W'(QMAX) << FRAC_BITS;
    localparam logic [CH_W:0]     NUM_CH_V = (CH_W + 1)'(NUM_CH);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] divisor;
    logic [CH_W-1:0]   ch;
    logic              accept, start, done;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] tbl [NUM_CH];

    assign accept = in_valid && in_ready;
    assign start  = accept && (in_max_abs != '0);

    scale_div_core #(.DATA_W(DATA_W)) u_core (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .divisor  (divisor),
        .dividend (DIVIDEND),
        .done     (done),
        .quotient (quotient)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (in_max_abs == '0) ? HOLD : DIV;
            DIV:     if (done) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == HOLD);
    end

    // Result registers and table are written only on the HOLD-entry edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divisor   <= '0;
            ch        <= '0;
            out_scale <= '0;
            out_ch    <= '0;
            out_zero  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) tbl[i] <= '0;
        end else if (accept) begin
            divisor <= in_max_abs;
            ch      <= in_ch;
            if (in_max_abs == '0) begin
                out_scale <= '0;
                out_ch    <= in_ch;
                out_zero  <= 1'b1;
                if ({1'b0, in_ch} < NUM_CH_V) tbl[in_ch] <= '0;
            end
        end else if (state == DIV && done) begin
            out_scale <= quotient;
            out_ch    <= ch;
            out_zero  <= 1'b0;
            if ({1'b0, ch} < NUM_CH_V) tbl[ch] <= quotient;
        end
    end

    always_comb begin
        rd_scale = '0;
        if ({1'b0, rd_ch} < NUM_CH_V) rd_scale = tbl[rd_ch];
    end
endmodule

// File: tb/tb_scale_divider.sv
// Randomized scoreboard bench for scale_divider; define SCALE_DIV_RADIX4_EN to match a radix-4 build.
module tb_scale_divider;
`ifdef SCALE_DIV_RADIX4_EN
    localparam int STEPS = 16;
`else
    localparam int STEPS = 32;
`endif
    localparam int NCH = 3;

    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_zero;
    logic [31:0] in_max_abs = '0, out_scale, rd_scale;
    logic [1:0]  in_ch = '0, out_ch, rd_ch = '0;

    typedef struct {
        longint unsigned scale;
        int              ch;
        bit              zero;
        int              acc;
        int              lat;
    } exp_t;

    exp_t            q[$];
    longint unsigned mtbl[NCH];
    int nvec = 0, nerr = 0, cyc = 0, ndone = 0, nexp = 0, stall = 0;

    scale_divider #(.NUM_CH(NCH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_max_abs(in_max_abs), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_scale(out_scale),
        .out_ch(out_ch), .out_zero(out_zero),
        .rd_ch(rd_ch), .rd_scale(rd_scale)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint unsigned ref_scale(input longint unsigned d);
        if (d == 0) return 0;
        return (64'd127 << 24) / d;
    endfunction

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Holds in_valid until accepted, so requests issued during DIV/HOLD are held off.
    task automatic send(input logic [31:0] d, input logic [1:0] c, input bit track);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; in_max_abs = d; in_ch = c;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        if (track) begin
            e.scale = ref_scale(d); e.ch = c; e.zero = (d == 0);
            e.acc = cyc + 1; e.lat = (d == 0) ? 0 : STEPS + 1;
            q.push_back(e);
            nexp++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (ndone < nexp && k < 300) begin @(negedge clk); k++; end
        if (ndone < nexp) chk("done_timeout", ndone, nexp);
    endtask

    task automatic check_tbl();
        for (int c = 0; c < 4; c++) begin
            rd_ch = c[1:0];
            #1 chk($sformatf("table[%0d]", c), rd_scale, (c < NCH) ? mtbl[c] : 0);
        end
    endtask

    // Monitor: pops the scoreboard on each new result, checks stability while stalled.
    initial begin : mon
        exp_t        e;
        logic [31:0] s0;
        logic [1:0]  c0;
        logic        z0;
        bit          busy;
        int          left;
        busy = 0; left = 0; s0 = '0; c0 = '0; z0 = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 0; out_ready = 1'b0;
            end else if (busy && out_ready) begin
                chk("valid_drop", out_valid, 0);
                chk("ready_after_consume", in_ready, 1);
                out_ready = 1'b0; busy = 0; ndone++;
            end else if (out_valid) begin
                if (!busy) begin
                    if (q.size() == 0) chk("spurious_valid", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("scale", out_scale, e.scale);
                        chk("ch", out_ch, e.ch);
                        chk("zero", out_zero, e.zero);
                        chk("latency", cyc - e.acc, e.lat);
                        if (e.ch < NCH) mtbl[e.ch] = e.scale;
                    end
                    busy = 1; left = stall; s0 = out_scale; c0 = out_ch; z0 = out_zero;
                end else begin
                    chk("hold_scale", out_scale, s0);
                    chk("hold_ch", out_ch, c0);
                    chk("hold_zero", out_zero, z0);
                    chk("hold_in_ready", in_ready, 0);
                end
                if (left == 0) out_ready = 1'b1;
                else left--;
            end
        end
    end

    initial begin : drv
        logic [31:0] d;
        for (int c = 0; c < NCH; c++) mtbl[c] = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_scale", out_scale, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_zero", out_zero, 0);
        check_tbl();

        send(32'd127, 2'd1, 1); wait_done(); check_tbl();
        send(32'd0, 2'd2, 1);   wait_done(); check_tbl();
        send(32'd1, 2'd0, 1);   wait_done();
        send(32'd3, 2'd1, 1);   wait_done();
        send(32'hFFFF_FFFF, 2'd2, 1); wait_done(); check_tbl();
        send(32'd5, 2'd3, 1);   wait_done(); check_tbl();

        // Stalled consumer with a second request held during DIV/HOLD.
        stall = 5;
        send(32'd3, 2'd0, 1);
        send(32'h55, 2'd2, 1);
        stall = 0;
        wait_done(); check_tbl();

        // Reset mid-DIV aborts; reset also clears the table.
        send(32'd9, 2'd1, 0);
        repeat (10) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int c = 0; c < NCH; c++) mtbl[c] = 0;
        @(negedge clk) reset = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        repeat (40) @(negedge clk);
        check_tbl();
        send(32'd127, 2'd1, 1); wait_done(); check_tbl();

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0:       d = 32'd0;
                1:       d = $urandom_range(1, 255);
                2:       d = $urandom;
                default: d = 32'd1 << $urandom_range(0, 31);
            endcase
            stall = $urandom_range(0, 3);
            send(d, 2'($urandom_range(0, 3)), 1);
            wait_done();
        end
        check_tbl();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
